signed_divider_8bits: RTL and testbench

Sequential two's-complement divider: 16-bit signed dividend by 8-bit signed divisor, producing an 8-bit signed quotient and an 8-bit signed remainder. It is the inverse companion of the 8-bit two's-complement multiplier. It uses the same start/DONE handshake, so a controller can chain multiply and divide on shared operand buses. Internally: restoring division on magnitudes over 8 iteration cycles, then sign fix-up.

---
 rtl/divider_pkg.sv | 16 +
 rtl/signed_divider_8bits_uc.sv | 49 ++++
 rtl/signed_divider_8bits.sv | 116 +++++++++++
 tb/tb_signed_divider_8bits.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared widths, limits and state encoding for the signed divider
package divider_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITER_COUNT = 8;
  localparam int QMAX_POS   = 127;
  localparam int QMAX_NEG   = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    FIN  = 3'd4
  } state_t;
endpackage

// File: rtl/signed_divider_8bits_uc.sv
// rtl/signed_divider_8bits_uc.sv - divider control unit: state machine and iteration counter
module signed_divider_8bits_uc
  import divider_pkg::*;
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_start,
  input  logic i_load_err,
  output logic o_load,
  output logic o_iter,
  output logic o_fix,
  output logic o_fin
);
  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD)
        r_cnt <= '0;
      else if (r_state == ITER)
        r_cnt <= r_cnt + 3'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? LOAD : IDLE;
      LOAD:    w_next = i_load_err ? FIN : ITER;
      ITER:    w_next = (r_cnt == 3'(ITER_COUNT - 1)) ? FIX : ITER;
      FIX:     w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_load = (r_state == LOAD);
    o_iter = (r_state == ITER);
    o_fix  = (r_state == FIX);
    o_fin  = (r_state == FIN);
  end
endmodule

// File: rtl/signed_divider_8bits.sv
// rtl/signed_divider_8bits.sv - 16/8 signed restoring divider datapath with sign fix-up
// Optional DIVIDER_PARTIAL_OUT_EN exposes partial quotient/remainder during ITER.
module signed_divider_8bits
  import divider_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  DONE,
  output logic                  ERR
);
  logic        w_load, w_iter, w_fix, w_fin;
  logic [15:0] w_dvd_abs;
  logic [7:0]  w_dvs_abs;
  logic        w_load_err;
  logic [8:0]  w_shift;
  logic        w_qbit;
  logic [7:0]  w_diff;
  logic [7:0]  w_rem_next;
  logic [7:0]  w_lo_next;
  logic        w_ovf;

  logic        r_sq, r_sr;
  logic [7:0]  r_dvs;
  logic [7:0]  r_rem;
  logic [7:0]  r_lo;
  logic [7:0]  r_q, r_r;
  logic        r_err, r_done;

  signed_divider_8bits_uc u_uc (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .i_start    (start),
    .i_load_err (w_load_err),
    .o_load     (w_load),
    .o_iter     (w_iter),
    .o_fix      (w_fix),
    .o_fin      (w_fin)
  );

  // Unsigned negation in the operand width already yields 32768 / 128 for the most negative inputs.
  always_comb begin
    w_dvd_abs  = dividend[15] ? (16'd0 - dividend) : dividend;
    w_dvs_abs  = divisor[7] ? (8'd0 - divisor) : divisor;
    w_load_err = (divisor == 8'd0) || (w_dvd_abs[15:8] >= w_dvs_abs);
  end

  // Partial remainder stays below the divisor, so the difference fits in 8 bits.
  always_comb begin
    w_shift    = {r_rem, r_lo[7]};
    w_qbit     = (w_shift >= {1'b0, r_dvs});
    w_diff     = w_shift[7:0] - r_dvs;
    w_rem_next = w_qbit ? w_diff : w_shift[7:0];
    w_lo_next  = {r_lo[6:0], w_qbit};
    w_ovf      = r_sq ? (r_lo > 8'(QMAX_NEG)) : (r_lo > 8'(QMAX_POS));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sq  <= 1'b0;
      r_sr  <= 1'b0;
      r_dvs <= '0;
      r_rem <= '0;
      r_lo  <= '0;
    end else if (w_load) begin
      r_sq  <= dividend[15] ^ divisor[7];
      r_sr  <= dividend[15];
      r_dvs <= w_dvs_abs;
      r_rem <= w_dvd_abs[15:8];
      r_lo  <= w_dvd_abs[7:0];
    end else if (w_iter) begin
      r_rem <= w_rem_next;
      r_lo  <= w_lo_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q    <= '0;
      r_r    <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_err <= w_load_err;
      end else if (w_iter) begin
`ifdef DIVIDER_PARTIAL_OUT_EN
        r_q <= w_lo_next;
        r_r <= w_rem_next;
`endif
      end else if (w_fix) begin
        if (w_ovf) begin
          r_err <= 1'b1;
          r_q   <= '0;
          r_r   <= '0;
        end else begin
          r_q <= r_sq ? (8'd0 - r_lo) : r_lo;
          r_r <= r_sr ? (8'd0 - r_rem) : r_rem;
        end
      end else if (w_fin && r_err) begin
        r_q <= '0;
        r_r <= '0;
      end
    end
  end

  assign quotient  = r_q;
  assign remainder = r_r;
  assign DONE      = r_done;
  assign ERR       = r_err;
endmodule

// File: tb/tb_signed_divider_8bits.sv
// tb/tb_signed_divider_8bits.sv - directed scoreboard bench for signed_divider_8bits
module tb_signed_divider_8bits;
  logic        CLK;
  logic        RESET_N;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        DONE;
  logic        ERR;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  signed_divider_8bits dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating integer division, remainder sign follows dividend.
  function automatic exp_t model(input logic signed [15:0] a, input logic signed [7:0] b);
    exp_t e;
    int ai, bi, ma, mb, qi, ri;
    ai = a;
    bi = b;
    ma = (ai < 0) ? -ai : ai;
    mb = (bi < 0) ? -bi : bi;
    e.q = '0; e.r = '0; e.err = 1'b0; e.lat = 11;
    if (bi == 0 || (ma / 256) >= mb) begin
      e.err = 1'b1;
      e.lat = 2;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      if (qi > 127 || qi < -128) e.err = 1'b1;
      else begin
        e.q = 8'(qi);
        e.r = 8'(ri);
      end
    end
    return e;
  endfunction

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat0);
    exp_t e;
    int   lat;
    lat = lat0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (DONE !== 1'b1 && lat < 40);
    e = sb.pop_front();
    if (DONE !== 1'b1) begin
      check({tag, "_timeout"}, 32'(DONE), 32'd1);
    end else begin
      check({tag, "_lat"}, 32'(lat), 32'(e.lat));
      check({tag, "_q"},   32'(quotient), 32'(e.q));
      check({tag, "_r"},   32'(remainder), 32'(e.r));
      check({tag, "_err"}, 32'(ERR), 32'(e.err));
    end
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [7:0] b);
    launch(a, b);
    wait_done(tag, 0);
  endtask

  initial begin
    int   n_done;
    exp_t e;
    RESET_N  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_q",    32'(quotient), 32'd0);
    check("rst_r",    32'(remainder), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err",  32'(ERR), 32'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    run("d100_m7", 16'd100, -8'sd7);
    @(posedge CLK); #1;
    check("done_pulse", 32'(DONE), 32'd0);
    run("m15_3",       -16'sd15, 8'd3);
    run("m16385_m128", -16'sd16385, -8'sd128);
    run("m16384_m128", -16'sd16384, -8'sd128);
    run("m16256_127",  -16'sd16256, 8'd127);
    run("m16384_127",  -16'sd16384, 8'd127);
    run("d55_0",       16'd55, 8'd0);
    run("d300_1",      16'd300, 8'd1);
    run("d1234_m56",   16'd1234, -8'sd56);
    run("m300_7",      -16'sd300, 8'd7);
    run("d32767_127",  16'd32767, 8'd127);

    // Back-to-back operations with start held high.
    dividend = 16'd7;
    divisor  = 8'd2;
    start    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = model(16'd7, 8'd2);
      if (i > 0) e.lat = 12;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    wait_done("held0", 0);
    wait_done("held1", 0);
    wait_done("held2", 0);
    start = 1'b0;

    // start toggling during ITER must be ignored.
    launch(16'd100, -8'sd7);
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      @(posedge CLK); #1;
    end
    start = 1'b0;
    wait_done("toggle", 5);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) n_done++;
    end
    check("toggle_no_extra_done", 32'(n_done), 32'd0);

    // Asynchronous reset in the middle of ITER aborts the operation.
    dividend = 16'd7;
    divisor  = 8'd2;
    start    = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("abort_q",    32'(quotient), 32'd0);
    check("abort_r",    32'(remainder), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_err",  32'(ERR), 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run("post_reset", -16'sd15, 8'd3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
